// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the 8-entry FIFO controller.
// The controller drives an external register file; it stores no data words itself.
package fifo_pkg;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        INIT     = 3'b000,
        NO_OP    = 3'b001,
        WRITE    = 3'b010,
        WR_ERROR = 3'b011,
        READ     = 3'b100,
        RD_ERROR = 3'b101
    } state_t;

endpackage

// File: rtl/fifo_next.sv
// Combinational next-state logic for the FIFO controller.
// Computes the next state, pointers and count, plus the accepted push/pop strobes.
module fifo_next
    import fifo_pkg::*;
(
    input  state_t           i_state,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    input  logic [PTR_W-1:0] i_wr_ptr,
    input  logic [PTR_W-1:0] i_rd_ptr,
    input  logic [CNT_W-1:0] i_count,
    output state_t           o_state_next,
    output logic [PTR_W-1:0] o_wr_ptr_next,
    output logic [PTR_W-1:0] o_rd_ptr_next,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_push,
    output logic             o_pop
);

    logic w_full;
    logic w_empty;
    logic w_wr_only;
    logic w_rd_only;

    assign w_full    = (i_count == CNT_W'(DEPTH));
    assign w_empty   = (i_count == '0);
    assign w_wr_only = i_wr_en && !i_rd_en;
    assign w_rd_only = i_rd_en && !i_wr_en;

    always_comb begin
        o_push        = w_wr_only && !w_full;
        o_pop         = w_rd_only && !w_empty;
        o_wr_ptr_next = i_wr_ptr;
        o_rd_ptr_next = i_rd_ptr;
        o_count_next  = i_count;

        if (w_wr_only) begin
            o_state_next = w_full ? WR_ERROR : WRITE;
        end else if (w_rd_only) begin
            o_state_next = w_empty ? RD_ERROR : READ;
        end else begin
            o_state_next = NO_OP;
        end

        // Unused encodings recover to NO_OP regardless of the request.
        case (i_state)
            INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR: ;
            default: o_state_next = NO_OP;
        endcase

        if (o_push) begin
            o_wr_ptr_next = i_wr_ptr + PTR_W'(1);
            o_count_next  = i_count + CNT_W'(1);
        end else if (o_pop) begin
            o_rd_ptr_next = i_rd_ptr + PTR_W'(1);
            o_count_next  = i_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller for an external 8-entry register file: write-enable decode,
// registered read mux, occupancy tracking and one-cycle request status pulses.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [8*DATA_W-1:0]   i_rf_q,
    output logic [7:0]            o_rf_we,
    output logic [DATA_W-1:0]     o_d_out,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_wr_ack,
    output logic                  o_wr_err,
    output logic                  o_rd_ack,
    output logic                  o_rd_err,
    output logic [3:0]            o_data_count
);

    state_t             r_state;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_d_out;

    state_t             w_state_next;
    logic [PTR_W-1:0]   w_wr_ptr_next;
    logic [PTR_W-1:0]   w_rd_ptr_next;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_push;
    logic               w_pop;
    logic [DATA_W-1:0]  w_rf_word [DEPTH];

    fifo_next u_next (
        .i_state       (r_state),
        .i_wr_en       (i_wr_en),
        .i_rd_en       (i_rd_en),
        .i_wr_ptr      (r_wr_ptr),
        .i_rd_ptr      (r_rd_ptr),
        .i_count       (r_count),
        .o_state_next  (w_state_next),
        .o_wr_ptr_next (w_wr_ptr_next),
        .o_rd_ptr_next (w_rd_ptr_next),
        .o_count_next  (w_count_next),
        .o_push        (w_push),
        .o_pop         (w_pop)
    );

    // The register file captures on the same edge, so the write enable stays combinational.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_rf_word[gi] = i_rf_q[gi*DATA_W +: DATA_W];
            assign o_rf_we[gi]   = w_push && !i_reset && (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= INIT;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_d_out  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            if (w_pop) begin
                r_d_out <= w_rf_word[r_rd_ptr];
            end
        end
    end

    assign o_d_out      = r_d_out;
    assign o_data_count = r_count;
    assign o_full       = (r_count == CNT_W'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_wr_ack     = (r_state == WRITE);
    assign o_wr_err     = (r_state == WR_ERROR);
    assign o_rd_ack     = (r_state == READ);
    assign o_rd_err     = (r_state == RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios then random push/pop traffic,
// compared against a queue-based model of the FIFO and a behavioural register file.
module tb_fifo_ctrl;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic            rd_en;
    logic [8*DW-1:0] rf_q;
    logic [7:0]      rf_we;
    logic [DW-1:0]   d_out;
    logic            full;
    logic            empty;
    logic            wr_ack;
    logic            wr_err;
    logic            rd_ack;
    logic            rd_err;
    logic [3:0]      data_count;

    logic [DW-1:0]   rf_mem [8];
    logic [DW-1:0]   wdata;

    fifo_ctrl #(.DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_wr_en      (wr_en),
        .i_rd_en      (rd_en),
        .i_rf_q       (rf_q),
        .o_rf_we      (rf_we),
        .o_d_out      (d_out),
        .o_full       (full),
        .o_empty      (empty),
        .o_wr_ack     (wr_ack),
        .o_wr_err     (wr_err),
        .o_rd_ack     (rd_ack),
        .o_rd_err     (rd_err),
        .o_data_count (data_count)
    );

    always #5 clk = ~clk;

    // Behavioural register file written by the controller's enables.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (rf_we[i]) rf_mem[i] <= wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) rf_q[i*DW +: DW] = rf_mem[i];
    end

    // Reference model: a queue of stored words plus the expected status of the last request.
    logic [DW-1:0] q [$];
    int unsigned   n_pushed;
    logic [DW-1:0] exp_dout;
    bit            e_wa, e_we, e_ra, e_re;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_state();
        check("data_count", 64'(data_count), 64'(q.size()));
        check("full",       64'(full),       64'(q.size() == 8));
        check("empty",      64'(empty),      64'(q.size() == 0));
        check("d_out",      64'(d_out),      64'(exp_dout));
        check("wr_ack",     64'(wr_ack),     64'(e_wa));
        check("wr_err",     64'(wr_err),     64'(e_we));
        check("rd_ack",     64'(rd_ack),     64'(e_ra));
        check("rd_err",     64'(rd_err),     64'(e_re));
    endtask

    task automatic model_reset();
        q.delete();
        n_pushed = 0;
        exp_dout = '0;
        {e_wa, e_we, e_ra, e_re} = 4'b0000;
    endtask

    // Entered and left at posedge+1: drive, check write enable, clock, update model, check.
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d);
        logic [7:0] exp_we;
        wr_en = w;
        rd_en = r;
        wdata = d;
        #1;
        exp_we = (w && !r && q.size() < 8) ? (8'h01 << (n_pushed % 8)) : 8'h00;
        check("rf_we", 64'(rf_we), 64'(exp_we));
        @(posedge clk);
        #1;
        {e_wa, e_we, e_ra, e_re} = 4'b0000;
        if (w && !r) begin
            if (q.size() < 8) begin
                q.push_back(d);
                n_pushed++;
                e_wa = 1'b1;
            end else begin
                e_we = 1'b1;
            end
        end else if (r && !w) begin
            if (q.size() > 0) begin
                exp_dout = q.pop_front();
                e_ra = 1'b1;
            end else begin
                e_re = 1'b1;
            end
        end
        $display("txn wr=%0d rd=%0d data=%08h -> count=%0d d_out=%08h ack/err=%0d%0d%0d%0d",
                 w, r, d, data_count, d_out, wr_ack, wr_err, rd_ack, rd_err);
        check_state();
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rf_we_rst", 64'(rf_we), 64'h0);
        check_state();
        reset = 1'b0;

        // Fill, overflow, drain, underflow.
        for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b0, 32'h11111111 * k);
        cycle(1'b1, 1'b0, 32'hDEADBEEF);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);

        // Pointer wrap: push 5, pop 5, push 5, pop 5.
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 32'hA0000000 + k);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, '0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 32'hB0000000 + k);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, '0);

        // Simultaneous request with three words stored.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'hC0000000 + k);
        cycle(1'b1, 1'b1, 32'h12345678);
        cycle(1'b0, 1'b0, '0);

        // Asynchronous reset between edges with four words stored, push pending.
        cycle(1'b1, 1'b0, 32'hC0000003);
        wr_en = 1'b1;
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("rf_we_async_rst", 64'(rf_we), 64'h0);
        check_state();
        @(posedge clk);
        #1;
        check("rf_we_rst_hold", 64'(rf_we), 64'h0);
        check_state();
        wr_en = 1'b0;
        reset = 1'b0;

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bit w, r;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            cycle(w, r, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
